// File: rtl/ethernet_pkg.sv
// Ethernet shared definitions.
// Used by the transmitter and the receiver.
package ethernet_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    PAD,
    FCS,
    DROP,
    IFG
  } eth_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam int          PREAMBLE_LEN  = 7;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ethernet_transmitter_if.sv
// Byte stream into the Ethernet transmitter.
// valid/ready handshake with end-of-frame marker.
interface ethernet_transmitter_if;

  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/ethernet_crc32.sv
// One-byte CRC-32 step, data bits LSB first.
// Pure combinational; the register lives in the caller.
module ethernet_crc32
  import ethernet_pkg::*;
(
  input  logic [7:0]  data,
  input  logic [31:0] crc,
  output logic [31:0] crc_next
);

  logic [31:0] c;

  // shift the eight data bits through the LFSR
  always_comb begin
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (data[i] ^ c[31]) begin
        c = {c[30:0], 1'b0} ^ CRC_POLY;
      end else begin
        c = {c[30:0], 1'b0};
      end
    end
    crc_next = c;
  end

endmodule

// File: rtl/ethernet_transmitter.sv
// GMII Ethernet frame transmitter.
// Adds preamble/SFD, pad and FCS; enforces IFG.
module ethernet_transmitter
  import ethernet_pkg::*;
#(
  parameter int MIN_PAYLOAD = 60,
  parameter int MAX_PAYLOAD = 1514,
  parameter int IFG_BYTES   = 12
) (
  input  logic                  clk_125m,
  input  logic                  rst,
  ethernet_transmitter_if.slave stream,
  output logic                  tx_en,
  output logic [7:0]            txd,
  output logic                  tx_er,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_length,
  output logic                  frame_error
);

  localparam logic [15:0] MIN_LEN  = 16'(MIN_PAYLOAD);
  localparam logic [15:0] MAX_LEN  = 16'(MAX_PAYLOAD);
  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
  localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 1);

  eth_state_e  state;
  eth_state_e  state_nx;
  logic [15:0] cnt;
  logic [15:0] cnt_nx;
  logic [15:0] pay_cnt;
  logic [15:0] pay_nx;
  logic [15:0] pay_inc;
  logic [15:0] len_nx;
  logic [31:0] crc;
  logic [31:0] crc_nx;
  logic [31:0] crc_step;
  logic [31:0] fcs;
  logic [7:0]  crc_in;
  logic [7:0]  fcs_byte;
  logic [7:0]  txd_nx;
  logic        tx_en_nx;
  logic        tx_er_nx;
  logic        done_nx;
  logic        err_nx;

  // state is the phase deciding next cycle's txd
  assign stream.s_ready = (state == DATA) ||
                          (state == DROP);

  assign pay_inc = sat_inc16(pay_cnt);
  assign crc_in  = (state == PAD) ? 8'h00
                                  : stream.s_data;
  assign fcs     = ~crc;

  ethernet_crc32 u_crc (
    .data     (crc_in),
    .crc      (crc),
    .crc_next (crc_step)
  );

  // FCS goes out low byte first
  always_comb begin
    fcs_byte = fcs[7:0];
    unique case (cnt[1:0])
      2'd0: fcs_byte = fcs[7:0];
      2'd1: fcs_byte = fcs[15:8];
      2'd2: fcs_byte = fcs[23:16];
      2'd3: fcs_byte = fcs[31:24];
    endcase
  end

  // next-state and next-output decode
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pay_nx   = pay_cnt;
    crc_nx   = crc;
    len_nx   = frame_length;
    tx_en_nx = 1'b0;
    txd_nx   = 8'h00;
    tx_er_nx = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (stream.s_valid) begin
          state_nx = PREAMBLE;
          tx_en_nx = 1'b1;
          txd_nx   = PREAMBLE_BYTE;
          cnt_nx   = 16'd1;
          pay_nx   = 16'd0;
          crc_nx   = CRC_INIT;
        end
      end
      PREAMBLE: begin
        tx_en_nx = 1'b1;
        txd_nx   = PREAMBLE_BYTE;
        if (cnt == PRE_LAST) begin
          state_nx = SFD;
          cnt_nx   = 16'd0;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      SFD: begin
        tx_en_nx = 1'b1;
        txd_nx   = SFD_BYTE;
        state_nx = DATA;
      end
      DATA: begin
        tx_en_nx = 1'b1;
        cnt_nx   = 16'd0;
        if (stream.s_valid) begin
          txd_nx = stream.s_data;
          crc_nx = crc_step;
          pay_nx = pay_inc;
          if (stream.s_last) begin
            state_nx = (pay_inc < MIN_LEN) ? PAD
                                           : FCS;
          end else if (pay_inc >= MAX_LEN) begin
            tx_er_nx = 1'b1;
            err_nx   = 1'b1;
            state_nx = DROP;
          end
        end else begin
          tx_er_nx = 1'b1;
          err_nx   = 1'b1;
          state_nx = IFG;
        end
      end
      PAD: begin
        tx_en_nx = 1'b1;
        crc_nx   = crc_step;
        pay_nx   = pay_inc;
        if (pay_inc >= MIN_LEN) begin
          state_nx = FCS;
          cnt_nx   = 16'd0;
        end
      end
      FCS: begin
        tx_en_nx = 1'b1;
        txd_nx   = fcs_byte;
        if (cnt[1:0] == 2'd3) begin
          done_nx  = 1'b1;
          len_nx   = pay_cnt + 16'd4;
          state_nx = IFG;
          cnt_nx   = 16'd0;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      DROP: begin
        if (stream.s_valid && stream.s_last) begin
          state_nx = IFG;
          cnt_nx   = 16'd0;
        end
      end
      IFG: begin
        if (cnt >= IFG_LAST) begin
          state_nx = IDLE;
          cnt_nx   = 16'd0;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // state, datapath and registered GMII outputs
  always_ff @(posedge clk_125m) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 16'd0;
      pay_cnt      <= 16'd0;
      crc          <= CRC_INIT;
      tx_en        <= 1'b0;
      txd          <= 8'h00;
      tx_er        <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      frame_error  <= 1'b0;
      frame_length <= 16'd0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      pay_cnt      <= pay_nx;
      crc          <= crc_nx;
      tx_en        <= tx_en_nx;
      txd          <= txd_nx;
      tx_er        <= tx_er_nx;
      busy         <= (state != IDLE) ||
                      (state_nx != IDLE);
      frame_done   <= done_nx;
      frame_error  <= err_nx;
      frame_length <= len_nx;
    end
  end

endmodule

// File: tb/tb_ethernet_transmitter.sv
// Scoreboard bench for ethernet_transmitter.
// Driver queues expected wire frames; monitor checks.
module tb_ethernet_transmitter;

  localparam int MINP = 60;
  localparam int MAXP = 1514;
  localparam int IFGB = 12;

  logic        clk_125m = 1'b0;
  logic        rst;
  logic        tx_en;
  logic [7:0]  txd;
  logic        tx_er;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_length;
  logic        frame_error;

  always #4 clk_125m = ~clk_125m;

  ethernet_transmitter_if tif ();

  ethernet_transmitter #(
    .MIN_PAYLOAD (MINP),
    .MAX_PAYLOAD (MAXP),
    .IFG_BYTES   (IFGB)
  ) dut (
    .clk_125m     (clk_125m),
    .rst          (rst),
    .stream       (tif),
    .tx_en        (tx_en),
    .txd          (txd),
    .tx_er        (tx_er),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_length (frame_length),
    .frame_error  (frame_error)
  );

  typedef struct {
    int nbytes;
    int er;
    bit done;
    int len;
    int errp;
    bit good;
    int gap;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_b[$];
  logic [7:0] pay[$];
  logic [7:0] got[$];

  int checks = 0;
  int errors = 0;

  bit in_frame = 0;
  bit mon_en   = 0;
  bit er_last;
  int er_cnt;
  int done_cnt;
  int done_idx;
  int done_len;
  int perr_cnt;
  int idle_cnt = 0;
  int start_gap;

  function automatic void chk(
    input string  name,
    input longint act,
    input longint req
  );
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d",
               name, act, req);
    end
  endfunction

  function automatic logic [31:0] crc_step(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (d[i] ^ r[31])
        r = (r << 1) ^ 32'h04C11DB7;
      else
        r = r << 1;
    end
    return r;
  endfunction

  function automatic void fill(
    input int n,
    input int mul,
    input int add
  );
    pay.delete();
    for (int i = 0; i < n; i++)
      pay.push_back(8'((i * mul + add) & 255));
  endfunction

  function automatic void push_pre();
    for (int i = 0; i < 7; i++)
      exp_b.push_back(8'h55);
    exp_b.push_back(8'hD5);
  endfunction

  function automatic void push_hdr(
    input int nb, input int er, input bit dn,
    input int ln, input int ep, input bit gd,
    input int gp
  );
    exp_t e;
    e.nbytes = nb;
    e.er     = er;
    e.done   = dn;
    e.len    = ln;
    e.errp   = ep;
    e.good   = gd;
    e.gap    = gp;
    exp_q.push_back(e);
  endfunction

  function automatic void exp_good(
    input int n,
    input int gap
  );
    logic [31:0] c;
    int tot;
    c = 32'hFFFFFFFF;
    push_pre();
    for (int i = 0; i < n; i++) begin
      exp_b.push_back(pay[i]);
      c = crc_step(c, pay[i]);
    end
    for (int i = n; i < MINP; i++) begin
      exp_b.push_back(8'h00);
      c = crc_step(c, 8'h00);
    end
    c = ~c;
    exp_b.push_back(c[7:0]);
    exp_b.push_back(c[15:8]);
    exp_b.push_back(c[23:16]);
    exp_b.push_back(c[31:24]);
    tot = ((n < MINP) ? MINP : n) + 4;
    push_hdr(8 + tot, 0, 1, tot, 0, 1, gap);
  endfunction

  function automatic void exp_cut(
    input int n,
    input bit err_byte,
    input bit er
  );
    push_pre();
    for (int i = 0; i < n; i++)
      exp_b.push_back(pay[i]);
    if (err_byte)
      exp_b.push_back(8'h00);
    push_hdr(8 + n + int'(err_byte), int'(er),
             0, 0, int'(er), 0, -1);
  endfunction

  function automatic bit rx_valid();
    logic [31:0] c;
    int n;
    n = got.size();
    if (n < 12 || er_cnt != 0) return 0;
    for (int i = 0; i < 7; i++)
      if (got[i] != 8'h55) return 0;
    if (got[7] != 8'hD5) return 0;
    c = 32'hFFFFFFFF;
    for (int i = 8; i < n - 4; i++)
      c = crc_step(c, got[i]);
    c = ~c;
    return got[n-4] == c[7:0] &&
           got[n-3] == c[15:8] &&
           got[n-2] == c[23:16] &&
           got[n-1] == c[31:24];
  endfunction

  function automatic void finish_frame();
    exp_t e;
    logic [7:0] b;
    int bad;
    int first;
    if (exp_q.size() == 0) begin
      chk("unexpected_frame_bytes", got.size(), 0);
      return;
    end
    e = exp_q.pop_front();
    chk("frame_bytes", got.size(), e.nbytes);
    bad = 0;
    first = -1;
    for (int i = 0; i < e.nbytes; i++) begin
      b = exp_b.pop_front();
      if (i < got.size() && got[i] != b) begin
        if (bad == 0) first = i;
        bad++;
      end
    end
    chk($sformatf("byte_mismatches(first=%0d)",
                  first), bad, 0);
    chk("tx_er_count", er_cnt, e.er);
    if (e.er != 0)
      chk("tx_er_on_last_byte", er_last, 1);
    chk("frame_done_count", done_cnt, e.done);
    if (e.done) begin
      chk("done_at_last_fcs", done_idx, got.size());
      chk("frame_length", done_len, e.len);
    end
    chk("frame_error_count", perr_cnt, e.errp);
    chk("rx_frame_valid", rx_valid(), e.good);
    if (e.gap >= 0)
      chk("ifg_idle_cycles", start_gap, e.gap);
  endfunction

  always @(negedge clk_125m) begin
    if (mon_en) begin
      if (tx_en) begin
        if (!in_frame) begin
          in_frame  = 1;
          got.delete();
          er_cnt    = 0;
          er_last   = 0;
          done_cnt  = 0;
          done_idx  = -1;
          done_len  = 0;
          perr_cnt  = 0;
          start_gap = idle_cnt;
        end
        got.push_back(txd);
        er_last  = tx_er;
        if (tx_er) er_cnt++;
        idle_cnt = 0;
      end else begin
        if (in_frame) begin
          in_frame = 0;
          finish_frame();
        end
        idle_cnt++;
      end
      if (frame_done) begin
        chk("done_while_tx_en", tx_en, 1);
        done_cnt++;
        done_idx = got.size();
        done_len = int'(frame_length);
      end
      if (frame_error) begin
        chk("error_while_tx_en", tx_en, 1);
        perr_cnt++;
      end
    end
  end

  task automatic send(input int n, input bit last);
    int i;
    int g;
    bit acc;
    i = 0;
    g = 0;
    tif.s_valid = 1'b1;
    tif.s_data  = pay[0];
    tif.s_last  = last && (n == 1);
    while (i < n && g < 4000) begin
      @(negedge clk_125m);
      acc = tif.s_ready;
      g++;
      @(posedge clk_125m);
      #1;
      if (acc) begin
        i++;
        if (i < n) begin
          tif.s_data = pay[i];
          tif.s_last = last && (i == n - 1);
        end
      end
    end
    if (i < n) chk("send_timeout", i, n);
    tif.s_valid = 1'b0;
    tif.s_last  = 1'b0;
    tif.s_data  = 8'h00;
  endtask

  task automatic check_reset_outputs();
    chk("rst_tx_en", tx_en, 0);
    chk("rst_txd", txd, 0);
    chk("rst_tx_er", tx_er, 0);
    chk("rst_s_ready", tif.s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_error", frame_error, 0);
    chk("rst_frame_length", frame_length, 0);
  endtask

  initial begin
    int g;
    int idle;
    rst         = 1'b1;
    tif.s_valid = 1'b0;
    tif.s_last  = 1'b0;
    tif.s_data  = 8'h00;
    repeat (3) @(posedge clk_125m);
    #1;
    rst    = 1'b0;
    mon_en = 1;
    @(negedge clk_125m);
    check_reset_outputs();

    fill(60, 1, 0);
    exp_good(60, -1);
    send(60, 1);

    fill(46, 1, 8'hA0);
    exp_good(46, -1);
    send(46, 1);

    fill(508, 7, 3);
    exp_good(508, -1);
    send(508, 1);
    fill(508, 13, 5);
    exp_good(508, IFGB);
    send(508, 1);

    fill(1515, 3, 1);
    exp_cut(MAXP, 0, 1);
    send(1515, 1);
    fill(60, 5, 9);
    exp_good(60, -1);
    send(60, 1);

    fill(20, 11, 2);
    exp_cut(20, 1, 1);
    send(20, 0);
    idle = 0;
    g = 0;
    while (busy && g < 60) begin
      @(negedge clk_125m);
      g++;
      if (!tx_en && busy) idle++;
    end
    chk("underrun_busy_low", busy, 0);
    chk("underrun_idle_cycles", idle, IFGB);

    fill(508, 17, 4);
    exp_cut(100, 0, 0);
    send(100, 0);
    rst = 1'b1;
    @(posedge clk_125m);
    #1;
    rst = 1'b0;
    @(negedge clk_125m);
    check_reset_outputs();
    fill(60, 9, 1);
    exp_good(60, -1);
    tif.s_valid = 1'b1;
    tif.s_data  = pay[0];
    tif.s_last  = 1'b0;
    @(posedge clk_125m);
    #1;
    chk("restart_tx_en", tx_en, 1);
    chk("restart_txd", txd, 8'h55);
    send(60, 1);

    g = 0;
    while ((exp_q.size() != 0 || in_frame) &&
           g < 3000) begin
      @(negedge clk_125m);
      g++;
    end
    chk("frames_outstanding", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ethernet_transmitter.md
ETHERNET_TRANSMITTER -- requirements
Module: ethernet_transmitter

Interface
REQ-001 Parameter MIN_PAYLOAD, default 60, minimum bytes before FCS (shorter frames zero-padded).
REQ-002 Parameter MAX_PAYLOAD, default 1514, maximum bytes before FCS.
REQ-003 Parameter IFG_BYTES, default 12, idle cycles enforced after every frame.
REQ-004 clk_125m  input  1  GMII transmit clock; all logic single clock domain, rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 s_data  input  8  payload byte (destination MAC onward; no preamble/SFD/FCS).
REQ-007 s_valid  input  1  s_data valid; once the first byte of a frame is accepted, s_valid SHALL stay high until s_last is accepted.
REQ-008 s_last  input  1  marks final payload byte.
REQ-009 s_ready  output  1  byte accepted when s_valid && s_ready.
REQ-010 tx_en  output  1  GMII TX_EN, registered.
REQ-011 txd  output  8  GMII TXD, registered.
REQ-012 tx_er  output  1  GMII TX_ER, registered; asserted only on abort.
REQ-013 busy  output  1  high from frame start through end of IFG.
REQ-014 frame_done  output  1  one-cycle pulse coincident with last FCS byte on txd.
REQ-015 frame_length  output  16  bytes sent after SFD incl. pad and FCS; valid with frame_done, held until next frame_done.
REQ-016 frame_error  output  1  one-cycle pulse when a frame is aborted (underrun or oversize).

Function
REQ-017 FSM states: IDLE, PREAMBLE, SFD, DATA, PAD, FCS, DROP, IFG.
REQ-018 IDLE: s_ready=0; s_valid=1 sampled in cycle 0 -> txd=8'h55, tx_en=1 in cycles 1-7, txd=8'hD5 in cycle 8.
REQ-019 s_ready SHALL be high in cycle 8 and in every DATA cycle; a byte accepted in cycle N SHALL appear on txd in cycle N+1.
REQ-020 s_last accepted with payload count < MIN_PAYLOAD -> PAD: txd=8'h00 until count = MIN_PAYLOAD; s_ready=0 in PAD.
REQ-021 FCS: CRC init 32'hFFFFFFFF over payload+pad; per byte, bits LSB first: if data[i]^crc[31] then crc=(crc<<1)^32'h04C11DB7 else crc=crc<<1; transmitted value ~crc, bytes [7:0],[15:8],[23:16],[31:24] in that order, s_ready=0.
REQ-022 After last FCS byte: tx_en=0, txd=0 for IFG_BYTES cycles; s_valid during IFG SHALL NOT start a frame; return to IDLE, busy drops after the last IFG cycle.
REQ-023 Back-to-back: earliest next preamble byte appears IFG_BYTES+1 cycles after the previous last FCS byte.
REQ-024 Underrun (s_valid=0 while s_ready=1 in DATA, including cycle 8): next cycle txd=0, tx_en=1, tx_er=1, frame_error=1; then IFG; no FCS, no frame_done.
REQ-025 Oversize (byte MAX_PAYLOAD accepted without s_last): next cycle tx_er=1, tx_en=1, frame_error=1; enter DROP with s_ready=1, tx_en=0, discarding until s_last accepted, then IFG.
REQ-026 Payload counter 16 bit, saturating; never wraps.
REQ-027 tx_er=0 and frame_error=0 in all cases not covered by REQ-024/025.

Reset
REQ-028 rst sampled high -> next cycle: state IDLE, tx_en=0, txd=0, tx_er=0, s_ready=0, busy=0, frame_done=0, frame_error=0, frame_length=0, CRC=32'hFFFFFFFF, counters 0.
REQ-029 Reset mid-frame truncates immediately; no IFG, no error pulse; a frame may start the first cycle after rst is released.

Structure
REQ-030 Package ethernet_pkg: FSM state enum, PREAMBLE_BYTE 8'h55, SFD_BYTE 8'hD5, CRC_POLY 32'h04C11DB7, CRC_INIT 32'hFFFFFFFF, PREAMBLE_LEN 7; shared with receiver.
REQ-031 One sub-module ethernet_crc32: combinational next-CRC from 8-bit data and 32-bit current CRC per REQ-021; CRC register held in ethernet_transmitter.

Verification
REQ-032 60-byte payload 0x00..0x3B, s_valid continuous -> 7x0x55, 0xD5, 60 bytes, 4 FCS equal to bench calc_crc result; frame_length=64, frame_done once.
REQ-033 46-byte payload -> 14 pad bytes of 0x00, FCS over 60 bytes; frame_length=64.
REQ-034 Two back-to-back 508-byte frames, s_valid held high -> exactly 12 tx_en=0 cycles between frames; each frame_length=512; receiver model reports frame_valid for both.
REQ-035 1515-byte payload -> tx_er pulse after byte 1514, frame_error=1, remaining byte dropped, no frame_done; next 60-byte frame sent correctly.
REQ-036 s_valid drops after 20 payload bytes -> tx_er=1 with tx_en=1 one cycle, frame_error=1, 12 idle cycles, busy then 0.
REQ-037 rst asserted at payload byte 100 of a 508-byte frame -> tx_en=0 next cycle, all outputs at reset values; new frame starts cycle after release.
